counter_scheduler: RTL
======================

# counter_scheduler

Time-shares the four Lab 1 down counters (ripple, synchronous, Johnson, schematic-entry) onto one LED display. It gates each counter's advance with a one-hot enable derived from the divided-clock tick. It clears a counter before handing it the display and rotates to the next counter after a programmable number of full count cycles or on a manual request. It sits between `clock_divider` and the counter instances in the top level, replacing the hand-edited "uncomment one counter" selection.

## Interface
Parameters:
- `DWELL`, default 2: full count cycles (terminal-state wraps) a counter runs before auto-rotation; legal range 1–15.
- `VAL_W`, default 4: width of each counter's value bus.

Ports:
- `clk` input 1: system clock (CLOCK_50 domain). The design has one clock.
- `rst` input 1: synchronous, active-high reset.
- `tick` input 1: single-cycle advance strobe derived from the divider bit.
- `start` input 1: level; leaves IDLE when high.
- `stop` input 1: level; returns to IDLE when high. Has priority over `start`.
- `auto` input 1: 1 = rotate after `DWELL` wraps; 0 = hold the current counter.
- `next_req` input 1: single-cycle manual rotate request.
- `cnt_val` input 4*VAL_W: values of counters 3..0; counter i occupies bits [i*VAL_W +: VAL_W].
- `cnt_term` input 4: counter i is in its terminal state (the state from which its next advance wraps).
- `cnt_en` output 4: one-hot advance enable to the counters.
- `cnt_clr` output 4: one-hot synchronous clear to the counters.
- `sel` output 2: index of the counter that owns the display.
- `out_val` output VAL_W: equals `cnt_val[sel*VAL_W +: VAL_W]`.
- `wrap` output 1: one-cycle pulse when the selected counter wraps.
- `busy` output 1: high in every state except IDLE.

## Operation
The FSM has four states: IDLE, CLEAR, RUN and SWITCH.
- **IDLE**:
  - All `cnt_en` and `cnt_clr` are 0. `sel` holds its value.
  - Goes to CLEAR when `start` is high and `stop` is low.
- **CLEAR**:
  - `cnt_clr[sel]` = 1 for exactly one cycle. The wrap tally is set to 0.
  - Goes to RUN next cycle; if `stop` is high, goes to IDLE.
- **RUN**:
  - `cnt_en[sel]` = `tick & ~stop & ~next_req`. This output is combinational and all other bits are 0.
  - A wrap is a cycle where `cnt_en[sel]` = 1 and `cnt_term[sel]` = 1. On a wrap, `wrap` pulses the next cycle and the tally increments.
  - Goes to SWITCH when:
    - `next_req` is high, or
    - `auto` is high and a wrap occurs with tally == DWELL-1.
  - `stop` has priority over both and sends the FSM to IDLE.
  - Simultaneous `tick` and `next_req`: the tick is dropped; the counter does not advance.
  - With `auto` = 0 the tally saturates at 15 and never triggers rotation.
- **SWITCH**:
  - Lasts one cycle. `sel` ← `sel`+1 mod 4, so 3 wraps to 0.
  - Goes to CLEAR; if `stop` is high, goes to IDLE.
- **Inputs outside RUN**: `next_req` and `tick` are ignored in IDLE, CLEAR and SWITCH.
- **`out_val`**: combinational mux of `cnt_val` by `sel`. It is valid in every state.

## Timing
- Reset values, including mid-operation: state IDLE, `sel` = 0, tally = 0, `cnt_clr` = 0, `wrap` = 0, `busy` = 0, `cnt_en` = 0 (combinational, forced 0 during `rst`).
- `rst` overrides every other input in the same edge.
- **Start-up**: `start` sampled high at edge N gives CLEAR at N+1 (`cnt_clr` high) and RUN at N+2. The first tick honoured is the one in the cycle after N+2.
- **Rotation latency**: a trigger at edge N gives SWITCH at N+1 (`sel` updates at the end of that cycle) and CLEAR at N+2 (`cnt_clr` for the new `sel`). Total dead time is 2 cycles with no `cnt_en`.
- `cnt_en` is combinational from `tick`, `stop`, `next_req` and registered state. `cnt_clr`, `sel`, `wrap` and `busy` are registered.
- The outgoing counter is left enabled-off at its current value. It is cleared again only when it is next selected.

## Structure
- Shared package `lab1_pkg` holds:
  - state localparams: IDLE = 2'd0, CLEAR = 2'd1, RUN = 2'd2, SWITCH = 2'd3;
  - `NUM_CNT` = 4;
  - default `VAL_W` = 4.
- One sub-module, `counter_sel_mux`: a 4:1 VAL_W-bit mux plus a 2-to-4 one-hot decoder, reused for `out_val` and the `cnt_en`/`cnt_clr` vectors.
- The tally is a 4-bit register inside `counter_scheduler`.

## Test plan
- **Reset mid-run**: assert `rst` during RUN with `sel` = 2. Required next cycle: `sel` = 0, `busy` = 0, `cnt_en` = 0, `cnt_clr` = 0.
- **Start sequence**: `start` pulse. Required: `cnt_clr` = 4'b0001 for one cycle, then each `tick` gives `cnt_en` = 4'b0001 in the same cycle.
- **Auto rotation, DWELL = 2**: drive `cnt_term[0]` on every 16th tick. Required after the 2nd wrap: `wrap` pulses twice in total, `sel` = 1 after 2 dead cycles, and `cnt_clr` = 4'b0010.
- **Manual rotate with simultaneous tick**, from `sel` = 3: drive `next_req` and `tick` in the same cycle. Required: `cnt_en` = 0 that cycle, then `sel` = 0 and `cnt_clr` = 4'b0001.
- **`auto` = 0**: run 20 wraps. Required: `sel` stays 0 and `wrap` pulses 20 times.
- **`stop` priority**: assert `stop` together with `tick` and a DWELL-reaching wrap. Required: `cnt_en` = 0, next state IDLE, `sel` unchanged.

Source files
------------

// File: rtl/lab1_pkg.sv
// rtl/lab1_pkg.sv - shared types and constants for the Lab 1 counter scheduler
package lab1_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        RUN    = 2'd2,
        SWITCH = 2'd3
    } sched_state_t;

    localparam int NUM_CNT   = 4;
    localparam int DEF_VAL_W = 4;

endpackage

// File: rtl/counter_sel_mux.sv
// rtl/counter_sel_mux.sv - 4:1 value mux plus 2-to-4 one-hot decoder of the selected counter
module counter_sel_mux
    import lab1_pkg::*;
#(
    parameter int VAL_W = DEF_VAL_W
) (
    input  logic [1:0]               sel,
    input  logic [NUM_CNT*VAL_W-1:0] vals,
    output logic [VAL_W-1:0]         val,
    output logic [NUM_CNT-1:0]       onehot
);

    // Pick the selected counter's value and its one-hot position
    always_comb begin
        val    = vals[sel*VAL_W +: VAL_W];
        onehot = 4'b0001 << sel;
    end

endmodule

// File: rtl/counter_scheduler.sv
// rtl/counter_scheduler.sv - time-shares four down counters onto one display with clear and rotation
module counter_scheduler
    import lab1_pkg::*;
#(
    parameter int DWELL = 2,
    parameter int VAL_W = DEF_VAL_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     auto,
    input  logic                     next_req,
    input  logic [NUM_CNT*VAL_W-1:0] cnt_val,
    input  logic [NUM_CNT-1:0]       cnt_term,
    output logic [NUM_CNT-1:0]       cnt_en,
    output logic [NUM_CNT-1:0]       cnt_clr,
    output logic [1:0]               sel,
    output logic [VAL_W-1:0]         out_val,
    output logic                     wrap,
    output logic                     busy
);

    localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

    sched_state_t         state_q, state_d;
    logic [1:0]           sel_q, sel_d;
    logic [3:0]           tally_q, tally_d;
    logic [NUM_CNT-1:0]   cnt_clr_q, cnt_clr_d;
    logic                 wrap_q, wrap_d;
    logic                 busy_q, busy_d;

    logic [NUM_CNT-1:0]   sel_onehot;
    logic                 en_go;
    logic                 wrap_ev;

    counter_sel_mux #(
        .VAL_W (VAL_W)
    ) u_sel_mux (
        .sel    (sel_q),
        .vals   (cnt_val),
        .val    (out_val),
        .onehot (sel_onehot)
    );

    // Advance enable is combinational so a tick reaches the counter in its own cycle;
    // a simultaneous manual request or stop swallows the tick
    always_comb begin
        en_go   = (state_q == RUN) && tick && !stop && !next_req && !rst;
        cnt_en  = en_go ? sel_onehot : '0;
        wrap_ev = en_go && cnt_term[sel_q];
    end

    // Next-state, tally, selection and registered-output computation
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        tally_d   = tally_q;
        cnt_clr_d = '0;
        wrap_d    = wrap_ev;
        case (state_q)
            IDLE: begin
                if (start && !stop) state_d = CLEAR;
            end
            CLEAR: begin
                tally_d = 4'd0;
                state_d = stop ? IDLE : RUN;
            end
            RUN: begin
                if (wrap_ev && tally_q != 4'hF) tally_d = tally_q + 4'd1;
                if (stop)
                    state_d = IDLE;
                else if (next_req || (auto && wrap_ev && tally_q == DWELL_LAST))
                    state_d = SWITCH;
            end
            SWITCH: begin
                sel_d   = sel_q + 2'd1;
                state_d = stop ? IDLE : CLEAR;
            end
            default: state_d = IDLE;
        endcase
        // Clear targets the counter that will own the display; leaving SWITCH it is the next one
        if (state_d == CLEAR)
            cnt_clr_d = (state_q == SWITCH) ? {sel_onehot[2:0], sel_onehot[3]} : sel_onehot;
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= 2'd0;
            tally_q   <= 4'd0;
            cnt_clr_q <= '0;
            wrap_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            tally_q   <= tally_d;
            cnt_clr_q <= cnt_clr_d;
            wrap_q    <= wrap_d;
            busy_q    <= busy_d;
        end
    end

    assign cnt_clr = cnt_clr_q;
    assign sel     = sel_q;
    assign wrap    = wrap_q;
    assign busy    = busy_q;

endmodule
